seg7_bcd_rx: RTL and testbench

Receive-side decoder for the 3-bit digit display path. It samples a 7-segment active-low pattern (segment order a..g, bit 0 = top segment a), debounces it for a programmable number of cycles, and decodes the legal digit glyphs 0–6 back to a 3-bit value. The value is delivered over a valid/ready handshake with a 1-entry pending buffer. It sits at the display-readback / loopback point, opposite the digit-to-segment driver, and flags illegal glyphs and overruns.

---
 rtl/seg7_bcd_rx.sv | 134 +++++++++++++
 tb/tb_seg7_bcd_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_rx.sv
// rtl/seg7_bcd_rx.sv - debounced 7-segment readback decoder with valid/ready digit output
// Optional error counter output err_cnt is enabled by defining SEG7_RX_ERRCNT_EN.
module seg7_bcd_rx #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:6] display,
    output logic [2:0] bcd,
    output logic       valid,
    input  logic       ready,
    output logic       err,
    output logic       ovr,
    input  logic       err_clr
`ifdef SEG7_RX_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
    localparam logic [0:6] BLANK  = 7'b1111111;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    logic [0:6] s0;
    logic [0:6] last;
    logic [7:0] cnt;
    logic [2:0] pend;
    logic       pend_full;

    logic       qual;
    logic       is_legal;
    logic       is_blank;
    logic       ev_legal;
    logic       ev_illegal;
    logic [2:0] dval;

    always_comb begin
        is_legal = 1'b1;
        dval     = 3'd0;
        case (s0)
            7'b0000001: dval = 3'd0;
            7'b1001111: dval = 3'd1;
            7'b0010010: dval = 3'd2;
            7'b0000110: dval = 3'd3;
            7'b1001100: dval = 3'd4;
            7'b0100100: dval = 3'd5;
            7'b1100000: dval = 3'd6;
            default:    is_legal = 1'b0;
        endcase
    end

    // one event per distinct stable pattern: last remembers what already fired
    assign is_blank   = (s0 == BLANK);
    assign qual       = (cnt == STABLE) && (s0 != last);
    assign ev_legal   = qual && is_legal;
    assign ev_illegal = qual && !is_legal && !is_blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0        <= BLANK;
            cnt       <= 8'd0;
            last      <= BLANK;
            pend      <= 3'd0;
            pend_full <= 1'b0;
            state     <= IDLE;
            bcd       <= 3'd0;
            valid     <= 1'b0;
            err       <= 1'b0;
            ovr       <= 1'b0;
`ifdef SEG7_RX_ERRCNT_EN
            err_cnt   <= 8'd0;
`endif
        end else begin
            s0 <= display;
            if (display != s0)
                cnt <= 8'd1;
            else
                cnt <= (cnt >= STABLE) ? STABLE : cnt + 8'd1;

            if (qual)
                last <= s0;

            if (ev_illegal)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;

`ifdef SEG7_RX_ERRCNT_EN
            if (ev_illegal)
                err_cnt <= (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
            else if (err_clr)
                err_cnt <= 8'd0;
`endif

            if ((state == HOLD) && !ready && ev_legal && pend_full)
                ovr <= 1'b1;
            else if (err_clr)
                ovr <= 1'b0;

            case (state)
                IDLE: begin
                    if (ev_legal) begin
                        bcd   <= dval;
                        valid <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        if (pend_full) begin
                            bcd <= pend;
                            if (ev_legal)
                                pend <= dval;
                            else
                                pend_full <= 1'b0;
                        end else if (ev_legal) begin
                            bcd <= dval;
                        end else begin
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (ev_legal) begin
                        // newest value wins when the single pending slot is already taken
                        pend      <= dval;
                        pend_full <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_bcd_rx.sv
// tb/tb_seg7_bcd_rx.sv - self-checking bench for seg7_bcd_rx
module tb_seg7_bcd_rx;
    localparam int S = 4;
    localparam logic [0:6] BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [0:6] display = BLANK;
    logic       ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] bcd;
    logic       valid;
    logic       err;
    logic       ovr;
`ifdef SEG7_RX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [0:6] glyph [7] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b1100000};

    seg7_bcd_rx #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .display(display), .bcd(bcd), .valid(valid),
        .ready(ready), .err(err), .ovr(ovr), .err_clr(err_clr)
`ifdef SEG7_RX_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // reference: window of the last S samples, output stream as a queue (head + one pending)
    logic [0:6] hist [$];
    logic [0:6] m_last;
    int         q [$];
    logic [2:0] m_bcd;
    logic       m_err;
    logic       m_ovr;
    int         m_cnt;

    function automatic int glyph_val(input logic [0:6] p);
        for (int i = 0; i < 7; i++)
            if (glyph[i] == p) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            hist.delete(); q.delete();
            m_last = BLANK; m_bcd = 3'd0; m_err = 1'b0; m_ovr = 1'b0; m_cnt = 0;
        end else begin
            bit ev, set_e, set_o;
            int v;
            logic [0:6] p;
            ev = 1'b0; set_e = 1'b0; set_o = 1'b0; p = BLANK;
            if (hist.size() == S) begin
                p = hist[0];
                ev = (p != m_last);
                foreach (hist[i]) if (hist[i] != p) ev = 1'b0;
            end
            if (q.size() > 0 && ready) void'(q.pop_front());
            if (ev) begin
                m_last = p;
                v = glyph_val(p);
                if (v >= 0) begin
                    q.push_back(v);
                    if (q.size() > 2) begin q.delete(1); set_o = 1'b1; end
                end else if (p != BLANK) begin
                    set_e = 1'b1;
                end
            end
            if (set_e) m_err = 1'b1; else if (err_clr) m_err = 1'b0;
            if (set_o) m_ovr = 1'b1; else if (err_clr) m_ovr = 1'b0;
            if (set_e) m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            else if (err_clr) m_cnt = 0;
            hist.push_back(display);
            if (hist.size() > S) void'(hist.pop_front());
            if (q.size() > 0) m_bcd = q[0][2:0];
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_count(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin tick(); if (valid === 1'b1) pulses++; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (bcd !== 3'd0) begin errors++; $display("FAIL reset_bcd: got %0d want 0", bcd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", ovr); end
`ifdef SEG7_RX_ERRCNT_EN
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_latency();
        int p;
        ready = 1'b1;
        display = 7'b0010010;
        for (int i = 0; i < S; i++) begin
            tick();
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL latency_early edge %0d: valid %b want 0", i, valid); end
        end
        tick();
        checks++; if (valid !== 1'b1 || bcd !== 3'd2) begin errors++; $display("FAIL latency_emit: valid %b bcd %0d want 1/2", valid, bcd); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL latency_single: valid %b want 0", valid); end
        run_count(10, p);
        checks++; if (p != 0) begin errors++; $display("FAIL no_reemit: pulses %0d want 0", p); end
    endtask

    task automatic test_glitch();
        display = 7'b0000110;
        repeat (3) begin
            tick();
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL glitch_short: valid %b want 0", valid); end
        end
        display = 7'b1001100;
        for (int i = 0; i < S; i++) begin
            tick();
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL glitch_early edge %0d: valid %b want 0", i, valid); end
        end
        tick();
        checks++; if (valid !== 1'b1 || bcd !== 3'd4) begin errors++; $display("FAIL glitch_emit: valid %b bcd %0d want 1/4", valid, bcd); end
        tick();
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        display = glyph[1]; repeat (S + 2) tick();
        checks++; if (valid !== 1'b1 || bcd !== 3'd1 || ovr !== 1'b0) begin errors++; $display("FAIL ovr_first: valid %b bcd %0d ovr %b want 1/1/0", valid, bcd, ovr); end
        display = glyph[5]; repeat (S + 2) tick();
        checks++; if (bcd !== 3'd1 || ovr !== 1'b0) begin errors++; $display("FAIL ovr_pend: bcd %0d ovr %b want 1/0", bcd, ovr); end
        display = glyph[6]; repeat (S + 2) tick();
        checks++; if (valid !== 1'b1 || bcd !== 3'd1 || ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: valid %b bcd %0d ovr %b want 1/1/1", valid, bcd, ovr); end
        ready = 1'b1;
        tick();
        checks++; if (valid !== 1'b1 || bcd !== 3'd6) begin errors++; $display("FAIL ovr_drain: valid %b bcd %0d want 1/6", valid, bcd); end
        tick();
        checks++; if (valid !== 1'b0 || ovr !== 1'b1) begin errors++; $display("FAIL ovr_empty: valid %b ovr %b want 0/1", valid, ovr); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", ovr); end
    endtask

    task automatic test_blank();
        int p;
        ready = 1'b1;
        display = glyph[1]; run_count(S + 2, p);
        checks++; if (p != 1 || bcd !== 3'd1) begin errors++; $display("FAIL blank_first: pulses %0d bcd %0d want 1/1", p, bcd); end
        display = BLANK; run_count(S + 2, p);
        checks++; if (p != 0) begin errors++; $display("FAIL blank_none: pulses %0d want 0", p); end
        display = glyph[1]; run_count(S + 2, p);
        checks++; if (p != 1) begin errors++; $display("FAIL blank_reemit: pulses %0d want 1", p); end
        display = glyph[2]; run_count(2, p);
        display = glyph[1]; run_count(2 * (S + 2), p);
        checks++; if (p != 0) begin errors++; $display("FAIL repeat_no_blank: pulses %0d want 0", p); end
    endtask

    task automatic test_err();
        display = 7'b1111110; repeat (S + 2) tick();
        checks++; if (err !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL err_set: err %b valid %b want 1/0", err, valid); end
`ifdef SEG7_RX_ERRCNT_EN
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL err_cnt_one: got %0d want 1", err_cnt); end
`endif
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", err); end
`ifdef SEG7_RX_ERRCNT_EN
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL err_cnt_clr: got %0d want 0", err_cnt); end
`endif
        display = 7'b1111100; repeat (S) tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", err); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", err); end
`ifdef SEG7_RX_ERRCNT_EN
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL err_cnt_set_wins: got %0d want 1", err_cnt); end
`endif
        err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    task automatic test_reset_midop();
        int p;
        ready = 1'b0;
        display = glyph[3]; repeat (S + 2) tick();
        display = glyph[4]; repeat (S + 2) tick();
        checks++; if (valid !== 1'b1 || bcd !== 3'd3) begin errors++; $display("FAIL midop_hold: valid %b bcd %0d want 1/3", valid, bcd); end
        reset = 1'b1; display = BLANK;
        tick();
        reset = 1'b0;
        checks++; if (valid !== 1'b0 || bcd !== 3'd0 || ovr !== 1'b0) begin errors++; $display("FAIL midop_reset: valid %b bcd %0d ovr %b want 0/0/0", valid, bcd, ovr); end
        ready = 1'b1;
        run_count(S + 4, p);
        checks++; if (p != 0) begin errors++; $display("FAIL midop_discard: pulses %0d want 0", p); end
    endtask

    task automatic test_random();
        int r, hold, cyc;
        cyc = 0;
        while (cyc < 600) begin
            r = $urandom_range(0, 9);
            if (r < 7) display = glyph[r];
            else if (r == 7) display = BLANK;
            else display = 7'($urandom);
            hold = $urandom_range(1, S + 3);
            repeat (hold) begin
                ready   = ($urandom_range(0, 1) == 1);
                err_clr = ($urandom_range(0, 15) == 0);
                reset   = ($urandom_range(0, 249) == 0);
                tick();
                cyc++;
                checks++;
                if (valid !== (q.size() > 0) || bcd !== m_bcd || err !== m_err || ovr !== m_ovr) begin
                    errors++;
                    $display("FAIL random cyc %0d: valid %b bcd %0d err %b ovr %b want %b/%0d/%b/%b",
                             cyc, valid, bcd, err, ovr, (q.size() > 0), m_bcd, m_err, m_ovr);
                end
`ifdef SEG7_RX_ERRCNT_EN
                checks++;
                if (err_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL random_err_cnt cyc %0d: got %0d want %0d", cyc, err_cnt, m_cnt); end
`endif
            end
        end
        reset = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_overrun();
        test_blank();
        test_err();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
